// File: rtl/exec_unit_if.sv
// Issue and CDB handshake bundle between reservation station, exec_unit and CDB arbiter.
// master = RS/arbiter side, slave = execution unit side.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

interface exec_unit_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = `ROB_TAG_LEN
);
   logic             issue_valid;
   logic [TAG_W-1:0] issue_tag;
   logic [3:0]       issue_op;
   logic [XLEN-1:0]  issue_a;
   logic [XLEN-1:0]  issue_b;
   logic             exec_stall;
   logic             cdb_req;
   logic             cdb_grant;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]  cdb_value;

   modport master (
      output issue_valid, issue_tag, issue_op, issue_a, issue_b, cdb_grant,
      input  exec_stall, cdb_req, cdb_valid, cdb_tag, cdb_value
   );

   modport slave (
      input  issue_valid, issue_tag, issue_op, issue_a, issue_b, cdb_grant,
      output exec_stall, cdb_req, cdb_valid, cdb_tag, cdb_value
   );
endinterface

// File: rtl/exec_unit.sv
// Integer ALU + pipelined multiplier feeding one CDB output register; ALU 2 / MUL MUL_STAGES+1 cycles.
// Backpressure: an ungranted output freezes the MUL pipe and the ALU stage; blocked issues see exec_stall.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module exec_unit #(
   parameter int XLEN       = 32,
   parameter int TAG_W      = `ROB_TAG_LEN,
   parameter int MUL_STAGES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       squash,
   output logic       busy,
   exec_unit_if.slave bus
);
   localparam int LAST = MUL_STAGES - 1;

   logic             alu_v;
   logic [TAG_W-1:0] alu_tag;
   logic [XLEN-1:0]  alu_res;

   logic [MUL_STAGES-1:0] mul_v;
   logic [TAG_W-1:0]      mul_tag [MUL_STAGES];
   logic [XLEN-1:0]       mul_res [MUL_STAGES];

   logic             out_v;
   logic [TAG_W-1:0] out_tag;
   logic [XLEN-1:0]  out_value;

   logic             out_free, sel_mul, sel_alu;
   logic             alu_hold, mul_hold;
   logic             is_mul, alu_acc, mul_acc;
   logic [4:0]       shamt;
   logic [XLEN-1:0]  alu_val, mul_val;
   logic [2*XLEN-1:0] prod;

   assign out_free = !out_v | bus.cdb_grant;
   assign sel_mul  = mul_v[LAST] & out_free;
   assign sel_alu  = alu_v & out_free & !mul_v[LAST];
   assign mul_hold = mul_v[LAST] & !sel_mul;
   assign alu_hold = alu_v & !sel_alu;

   assign is_mul  = (bus.issue_op == 4'd10) || (bus.issue_op == 4'd11);
   assign bus.exec_stall = bus.issue_valid & (is_mul ? mul_hold : alu_hold);
   assign alu_acc = bus.issue_valid & !is_mul & !alu_hold & !squash;
   assign mul_acc = bus.issue_valid & is_mul & !mul_hold & !squash;

   assign bus.cdb_req   = out_v;
   assign bus.cdb_valid = out_v & bus.cdb_grant;
   assign bus.cdb_tag   = out_tag;
   assign bus.cdb_value = out_value;
   assign busy          = alu_v | (|mul_v) | out_v;

   assign shamt = bus.issue_b[4:0];
   assign prod  = {{XLEN{1'b0}}, bus.issue_a} * {{XLEN{1'b0}}, bus.issue_b};
   assign mul_val = (bus.issue_op == 4'd11) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

   always_comb begin
      alu_val = '0;
      case (bus.issue_op)
         4'd0: alu_val = bus.issue_a + bus.issue_b;
         4'd1: alu_val = bus.issue_a - bus.issue_b;
         4'd2: alu_val = bus.issue_a & bus.issue_b;
         4'd3: alu_val = bus.issue_a | bus.issue_b;
         4'd4: alu_val = bus.issue_a ^ bus.issue_b;
         4'd5: alu_val = bus.issue_a << shamt;
         4'd6: alu_val = bus.issue_a >> shamt;
         4'd7: alu_val = $signed(bus.issue_a) >>> shamt;
         4'd8: alu_val = {{(XLEN-1){1'b0}}, $signed(bus.issue_a) < $signed(bus.issue_b)};
         4'd9: alu_val = {{(XLEN-1){1'b0}}, bus.issue_a < bus.issue_b};
         default: alu_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_v     <= 1'b0;
         alu_tag   <= '0;
         alu_res   <= '0;
         mul_v     <= '0;
         out_v     <= 1'b0;
         out_tag   <= '0;
         out_value <= '0;
         for (int i = 0; i < MUL_STAGES; i++) begin
            mul_tag[i] <= '0;
            mul_res[i] <= '0;
         end
      end else if (squash) begin
         alu_v <= 1'b0;
         mul_v <= '0;
         out_v <= 1'b0;
      end else begin
         if (sel_mul) begin
            out_v     <= 1'b1;
            out_tag   <= mul_tag[LAST];
            out_value <= mul_res[LAST];
         end else if (sel_alu) begin
            out_v     <= 1'b1;
            out_tag   <= alu_tag;
            out_value <= alu_res;
         end else if (bus.cdb_grant) begin
            out_v <= 1'b0;
         end

         if (alu_acc) begin
            alu_v   <= 1'b1;
            alu_tag <= bus.issue_tag;
            alu_res <= alu_val;
         end else if (sel_alu) begin
            alu_v <= 1'b0;
         end

         // Bubbles shift too, so a full pipe only stalls when its head is blocked.
         if (!mul_hold) begin
            for (int i = LAST; i > 0; i--) begin
               mul_v[i]   <= mul_v[i-1];
               mul_tag[i] <= mul_tag[i-1];
               mul_res[i] <= mul_res[i-1];
            end
            mul_v[0] <= mul_acc;
            if (mul_acc) begin
               mul_tag[0] <= bus.issue_tag;
               mul_res[0] <= mul_val;
            end
         end
      end
   end
endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed scenarios plus randomized traffic against a plain-arithmetic model.
module tb_exec_unit;
   localparam int XLEN = 32;
   localparam int TAG_W = 6;
   localparam int MS = 4;

   logic clk = 1'b0;
   logic reset, squash, busy;

   exec_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();

   exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_STAGES(MS)) dut (
      .clk(clk), .reset(reset), .squash(squash), .busy(busy), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      val;
      int               issue_cyc;
      int               lat;
   } exp_t;

   exp_t alu_q[$];
   exp_t mul_q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit stop_rand = 0;
   logic [TAG_W-1:0] tag_ctr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned p;
      int sh, sa;
      sh = int'(b[4:0]);
      sa = a;
      p = longint'({32'b0, a}) * longint'({32'b0, b});
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << sh;
         4'd6: return a >> sh;
         4'd7: return sa >>> sh;
         4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd9: return (a < b) ? 32'd1 : 32'd0;
         4'd10: return p[31:0];
         4'd11: return p[63:32];
         default: return 32'd0;
      endcase
   endfunction

   // Monitor: pops per-class queues on each broadcast; also checks strobe and hold stability.
   logic prev_wait = 1'b0;
   logic [TAG_W-1:0] prev_tag;
   logic [31:0] prev_val;
   always @(negedge clk) begin
      exp_t e;
      bit found;
      if (!reset) begin
         check("cdb_valid_strobe", bus.cdb_valid, bus.cdb_req & bus.cdb_grant);
         if (prev_wait) begin
            check("hold_req", bus.cdb_req, 1);
            check("hold_tag", bus.cdb_tag, prev_tag);
            check("hold_value", bus.cdb_value, prev_val);
         end
         if (bus.cdb_valid) begin
            found = 1'b0;
            if (alu_q.size() > 0 && alu_q[0].tag == bus.cdb_tag) begin
               e = alu_q.pop_front(); found = 1'b1;
            end else if (mul_q.size() > 0 && mul_q[0].tag == bus.cdb_tag) begin
               e = mul_q.pop_front(); found = 1'b1;
            end
            total++;
            if (!found) begin
               bad++;
               $display("FAIL unexpected_broadcast: tag %0d value %0h, required no broadcast or a queue-head tag",
                        bus.cdb_tag, bus.cdb_value);
            end else begin
               check("result_value", bus.cdb_value, e.val);
               if (e.lat > 0) check("latency", cyc - e.issue_cyc, e.lat);
            end
         end
      end
      prev_wait = bus.cdb_req & !bus.cdb_grant & !reset & !squash;
      prev_tag  = bus.cdb_tag;
      prev_val  = bus.cdb_value;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input int lat, output int stalls);
      bit acc;
      exp_t e;
      acc = 1'b0;
      stalls = 0;
      bus.issue_valid = 1'b1;
      bus.issue_op = op;
      bus.issue_a = a;
      bus.issue_b = b;
      bus.issue_tag = tag;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         if (!bus.exec_stall) acc = 1'b1;
         else stalls++;
      end
      if (!acc) begin
         total++; bad++;
         $display("FAIL issue_timeout: op %0d tag %0d still stalled, required acceptance", op, tag);
      end else begin
         e = '{tag: tag, val: model(op, a, b), issue_cyc: cyc, lat: lat};
         if (op == 4'd10 || op == 4'd11) mul_q.push_back(e);
         else alu_q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.issue_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 500 && !done; n++) begin
         if (alu_q.size() == 0 && mul_q.size() == 0 && !busy) done = 1'b1;
         else tick(1);
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL drain_timeout: %0d alu / %0d mul results outstanding, required 0",
                  alu_q.size(), mul_q.size());
      end
   endtask

   task automatic quiet_window(input int n);
      tick(n);
      check("quiet_queues", alu_q.size() + mul_q.size(), 0);
   endtask

   initial begin
      int st;
      logic [3:0] op;
      logic [31:0] a, b;
      reset = 1'b1;
      squash = 1'b0;
      bus.issue_valid = 1'b0;
      bus.issue_op = '0;
      bus.issue_a = '0;
      bus.issue_b = '0;
      bus.issue_tag = '0;
      bus.cdb_grant = 1'b0;
      tick(3);
      @(negedge clk);
      check("rst_cdb_req", bus.cdb_req, 0);
      check("rst_cdb_valid", bus.cdb_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_stall", bus.exec_stall, 0);
      check("rst_tag", bus.cdb_tag, 0);
      check("rst_value", bus.cdb_value, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Basic ALU latency
      bus.cdb_grant = 1'b1;
      issue(4'd0, 32'd5, 32'd7, 6'd3, 2, st);
      drain();

      // MUL then MULHU back to back
      issue(4'd10, 32'hFFFF_FFFF, 32'd2, 6'd4, MS + 1, st);
      issue(4'd11, 32'hFFFF_FFFF, 32'd2, 6'd5, MS + 1, st);
      check("mulhu_back_to_back_stall", st, 0);
      drain();

      // ALU result collides with MUL at the output: MUL wins, SUB one cycle later
      issue(4'd10, 32'd6, 32'd9, 6'd1, MS + 1, st);
      tick(2);
      issue(4'd1, 32'd3, 32'd5, 6'd2, 3, st);
      check("collide_no_stall", st, 0);
      drain();

      // Shift/compare/illegal corners
      issue(4'd7, 32'h8000_0000, 32'd31, 6'd6, 2, st);
      issue(4'd8, 32'hFFFF_FFFF, 32'd1, 6'd7, 2, st);
      issue(4'd9, 32'hFFFF_FFFF, 32'd1, 6'd8, 2, st);
      issue(4'd13, 32'h1234_5678, 32'h9, 6'd9, 2, st);
      check("alu_back_to_back_stall", st, 0);
      drain();

      // Output blocked: two ALU ops absorbed, third stalls until grant returns
      bus.cdb_grant = 1'b0;
      issue(4'd0, 32'd1, 32'd2, 6'd10, 0, st);
      check("blocked_first_stall", st, 0);
      issue(4'd4, 32'hF0F0, 32'h0FF0, 6'd11, 0, st);
      check("blocked_second_stall", st, 0);
      fork
         begin tick(10); bus.cdb_grant = 1'b1; end
      join_none
      issue(4'd2, 32'hFF00, 32'h0F0F, 6'd12, 0, st);
      check("blocked_third_stalled", st >= 8, 1);
      issue(4'd3, 32'h1, 32'h2, 6'd13, 0, st);
      drain();

      // Squash with a result in out and a MUL in stage 2
      bus.cdb_grant = 1'b0;
      issue(4'd0, 32'd40, 32'd2, 6'd14, 0, st);
      issue(4'd10, 32'd3, 32'd3, 6'd15, 0, st);
      tick(1);
      check("pre_squash_busy", busy, 1);
      squash = 1'b1;
      tick(1);
      squash = 1'b0;
      alu_q.delete();
      mul_q.delete();
      bus.cdb_grant = 1'b1;
      @(negedge clk);
      check("squash_busy", busy, 0);
      check("squash_req", bus.cdb_req, 0);
      quiet_window(12);

      // Reset mid-operation
      bus.cdb_grant = 1'b0;
      issue(4'd1, 32'd9, 32'd4, 6'd16, 0, st);
      issue(4'd11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 6'd17, 0, st);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      alu_q.delete();
      mul_q.delete();
      bus.cdb_grant = 1'b1;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_req", bus.cdb_req, 0);
      check("midrst_value", bus.cdb_value, 0);
      quiet_window(12);

      // Randomized traffic with random grant
      fork
         begin
            while (!stop_rand) begin
               @(posedge clk); #1;
               bus.cdb_grant = ($urandom_range(0, 3) != 0);
            end
         end
      join_none
      tag_ctr = 6'd20;
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(10, 11));
         a = $urandom();
         b = $urandom();
         if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
         if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
         issue(op, a, b, tag_ctr, 0, st);
         tag_ctr = tag_ctr + 1'b1;
         if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
      end
      stop_rand = 1'b1;
      tick(2);
      bus.cdb_grant = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
